// File: rtl/coprocessor_pio_ctrl_if.sv
// Avalon-MM slave bus bundle for the coprocessor PIO controller.
// The master modport drives the bus and the slave modport answers reads.
interface coprocessor_pio_ctrl_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/coprocessor_pio_ctrl.sv
// Coprocessor control/status PIO: atomic set/clear, timed strobe pulses,
// synchronised status input with rising-edge capture and maskable interrupt.
module coprocessor_pio_ctrl #(
    parameter int unsigned WIDTH        = 6,
    parameter int unsigned RESET_VALUE  = 1,
    parameter int unsigned PULSE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    coprocessor_pio_ctrl_if.slave bus,
    output logic [WIDTH-1:0]     out_port,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);
    localparam logic [31:0]      RESET_WORD = 32'(RESET_VALUE);
    localparam logic [WIDTH-1:0] DATA_RST   = RESET_WORD[WIDTH-1:0];
    localparam logic [15:0]      PULSE_LEN  = 16'(PULSE_CYCLES);
    localparam logic [WIDTH-1:0] ZERO_W     = {WIDTH{1'b0}};

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] pulse_mask_q, pulse_mask_d;
    logic [15:0]      count_q, count_d;
    logic [WIDTH-1:0] sync0_q, sync1_q, sync1_dly_q;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;

    logic             wr_s;
    logic             busy_s;
    logic [WIDTH-1:0] wdata_s;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] w1c_s;
    logic             unused_s;

    assign wr_s     = bus.chipselect & ~bus.write_n;
    assign wdata_s  = bus.writedata[WIDTH-1:0];
    assign busy_s   = (count_q != 16'd0);
    assign rise_s   = sync1_q & ~sync1_dly_q;
    assign unused_s = ^bus.writedata[31:WIDTH];

    // Next-state for all software-visible registers.
    always_comb begin
        data_d       = data_q;
        pulse_mask_d = pulse_mask_q;
        count_d      = count_q;
        irq_mask_d   = irq_mask_q;
        w1c_s        = ZERO_W;

        if (wr_s) begin
            case (bus.address)
                3'd0:    data_d = wdata_s;
                3'd1:    data_d = data_q | wdata_s;
                3'd2:    data_d = data_q & ~wdata_s;
                3'd5:    w1c_s = wdata_s;
                3'd6:    irq_mask_d = wdata_s;
                default: data_d = data_q;
            endcase
        end else begin
            data_d = data_q;
        end

        // A zero mask written to PULSE cancels any strobe in flight.
        if (wr_s && (bus.address == 3'd3)) begin
            if (wdata_s != ZERO_W) begin
                pulse_mask_d = wdata_s;
                count_d      = PULSE_LEN;
            end else begin
                pulse_mask_d = ZERO_W;
                count_d      = 16'd0;
            end
        end else if (busy_s) begin
            count_d = count_q - 16'd1;
            if (count_q == 16'd1) begin
                pulse_mask_d = ZERO_W;
            end else begin
                pulse_mask_d = pulse_mask_q;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Fresh edges override a same-cycle write-one-to-clear.
    assign edge_d = (edge_q & ~w1c_s) | rise_s;

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q       <= DATA_RST;
            pulse_mask_q <= ZERO_W;
            count_q      <= 16'd0;
            sync0_q      <= ZERO_W;
            sync1_q      <= ZERO_W;
            sync1_dly_q  <= ZERO_W;
            edge_q       <= ZERO_W;
            irq_mask_q   <= ZERO_W;
        end else begin
            data_q       <= data_d;
            pulse_mask_q <= pulse_mask_d;
            count_q      <= count_d;
            sync0_q      <= in_port;
            sync1_q      <= sync0_q;
            sync1_dly_q  <= sync1_q;
            edge_q       <= edge_d;
            irq_mask_q   <= irq_mask_d;
        end
    end

    assign out_port = data_q | (busy_s ? pulse_mask_q : ZERO_W);
    assign irq      = |(edge_q & irq_mask_q);

    // Zero-wait-state read mux.
    always_comb begin
        case (bus.address)
            3'd0:    bus.readdata = 32'(data_q);
            3'd3:    bus.readdata = 32'(pulse_mask_q) | {busy_s, 31'd0};
            3'd4:    bus.readdata = 32'(sync1_q);
            3'd5:    bus.readdata = 32'(edge_q);
            3'd6:    bus.readdata = 32'(irq_mask_q);
            default: bus.readdata = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_coprocessor_pio_ctrl.sv
// Directed bench for coprocessor_pio_ctrl with a cycle-level reference model.
module tb_coprocessor_pio_ctrl;
    localparam int W  = 6;
    localparam int RV = 1;
    localparam int PC = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] out_port;
    logic [W-1:0] in_port;
    logic         irq;

    coprocessor_pio_ctrl_if bus();

    coprocessor_pio_ctrl #(.WIDTH(W), .RESET_VALUE(RV), .PULSE_CYCLES(PC)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .out_port (out_port),
        .in_port  (in_port),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference model: software-visible state plus a short input history.
    logic [W-1:0] m_data, m_mask, m_edge, m_irqm;
    logic [W-1:0] h0, h1, h2;
    int           m_left;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [2:0] a);
        logic [31:0] r;
        r = 32'd0;
        case (a)
            3'd0: r = 32'(m_data);
            3'd3: r = 32'(m_mask) | ((m_left > 0) ? 32'h8000_0000 : 32'd0);
            3'd4: r = 32'(h1);
            3'd5: r = 32'(m_edge);
            3'd6: r = 32'(m_irqm);
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic model_step();
        logic [W-1:0] wd, ne;
        bit           wr;
        if (reset) begin
            m_data = W'(RV); m_mask = '0; m_left = 0; m_edge = '0; m_irqm = '0;
            h0 = '0; h1 = '0; h2 = '0;
        end else begin
            wd = bus.writedata[W-1:0];
            wr = bus.chipselect && !bus.write_n;
            // status is in_port delayed two clocks; an edge is a rise of that status
            ne = h1 & ~h2;
            h2 = h1; h1 = h0; h0 = in_port;
            if (wr && bus.address == 3'd3) begin
                m_mask = wd;
                m_left = (wd != '0) ? PC : 0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_mask = '0;
            end
            if (wr && bus.address == 3'd0) m_data = wd;
            if (wr && bus.address == 3'd1) m_data = m_data | wd;
            if (wr && bus.address == 3'd2) m_data = m_data & ~wd;
            if (wr && bus.address == 3'd6) m_irqm = wd;
            m_edge = (m_edge & ~((wr && bus.address == 3'd5) ? wd : '0)) | ne;
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_port", 32'(out_port), 32'(m_data | ((m_left > 0) ? m_mask : '0)));
            check("irq", 32'(irq), 32'(|(m_edge & m_irqm)));
            check("readdata", bus.readdata, m_read(bus.address));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        tick();
        bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'd0;
    endtask

    task automatic rd(input string name, input logic [2:0] a, input logic [31:0] exp);
        bus.address = a;
        #1;
        check(name, bus.readdata, exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.address = 3'(i);
            tick();
        end
    endtask

    initial begin
        reset = 1'b1; in_port = '0;
        bus.address = 3'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'd0;
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;

        check("rst_out", 32'(out_port), 32'h01);
        check("rst_irq", 32'(irq), 32'd0);
        rd("rst_addr0", 3'd0, 32'h0000_0001);
        rd("rst_addr3", 3'd3, 32'd0);
        idle(8);

        wr(3'd0, 32'h3C); check("data_wr", 32'(out_port), 32'h3C);
        wr(3'd1, 32'h03); check("set_wr", 32'(out_port), 32'h3F);
        rd("set_read", 3'd1, 32'd0);
        wr(3'd2, 32'hFFFF_FF0C); check("clr_wr", 32'(out_port), 32'h33);
        rd("clr_read", 3'd2, 32'd0);
        rd("addr7_read", 3'd7, 32'd0);

        wr(3'd0, 32'h00);
        wr(3'd3, 32'h20);
        check("pulse_on", 32'(out_port), 32'h20);
        rd("pulse_busy", 3'd3, 32'h8000_0020);
        for (int i = 0; i < 3; i++) begin
            tick(); check("pulse_hold", 32'(out_port), 32'h20);
        end
        tick(); check("pulse_off", 32'(out_port), 32'h00);
        rd("pulse_idle", 3'd3, 32'd0);

        wr(3'd3, 32'h20); tick(); wr(3'd3, 32'h20);
        for (int i = 0; i < 3; i++) begin
            tick(); check("pulse_ext", 32'(out_port), 32'h20);
        end
        tick(); check("pulse_ext_off", 32'(out_port), 32'h00);

        wr(3'd3, 32'h20); tick(); wr(3'd3, 32'h00);
        check("pulse_cancel", 32'(out_port), 32'h00);
        rd("pulse_cancel_rd", 3'd3, 32'd0);
        idle(4);

        wr(3'd6, 32'h01);
        in_port = 6'h01;
        tick(); tick();
        rd("edge_early", 3'd5, 32'd0);
        tick();
        rd("edge0", 3'd5, 32'h01);
        rd("status0", 3'd4, 32'h01);
        check("irq_on", 32'(irq), 32'd1);
        wr(3'd5, 32'h01);
        check("irq_w1c", 32'(irq), 32'd0);
        rd("edge_w1c", 3'd5, 32'd0);
        in_port = 6'h03;
        tick(); tick(); tick();
        rd("edge1", 3'd5, 32'h02);
        check("irq_masked", 32'(irq), 32'd0);

        in_port = 6'h02;
        tick(); tick(); tick();
        in_port = 6'h03;
        tick(); tick();
        wr(3'd5, 32'h01);
        rd("edge_wins", 3'd5, 32'h03);
        check("irq_edge_wins", 32'(irq), 32'd1);
        wr(3'd5, 32'h02);
        rd("edge_clr1", 3'd5, 32'h01);
        idle(4);

        wr(3'd0, 32'h3F);
        wr(3'd3, 32'h20);
        tick();
        bus.address = 3'd0; bus.writedata = 32'h15; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'd0;
        check("rst_mid_out", 32'(out_port), 32'h01);
        rd("rst_mid_addr3", 3'd3, 32'd0);
        rd("rst_mid_edge", 3'd5, 32'd0);
        check("rst_mid_irq", 32'(irq), 32'd0);
        tick(); tick(); tick();
        rd("edge_after_rst", 3'd5, 32'h03);
        check("irq_after_rst", 32'(irq), 32'd0);
        idle(8);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
